uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter PARITY_EN, default 1: 1 = even parity bit inserted after data; 0 = no parity bit.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port clks_per_bit  input  10  bit-period control; each line bit is held for clks_per_bit+1 clk cycles.
REQ-005 SHALL provide port data_in  input  8  byte to transmit; LSB is sent first.
REQ-006 SHALL provide port tx_valid  input  1  high when data_in holds a byte to send.
REQ-007 SHALL provide port tx_ready  output  1  high when the one-entry holding buffer is empty and can accept a byte.
REQ-008 SHALL provide port TX  output  1  serial line; idles high.
REQ-009 SHALL provide port busy  output  1  high while a frame is on the line (START through STOP).
REQ-010 SHALL provide port tx_done  output  1  one-cycle pulse in the last cycle of each stop bit.

Function
REQ-011 SHALL accept a byte on any rising edge where tx_valid && tx_ready, capturing data_in into the holding buffer.
REQ-012 SHALL deassert tx_ready in the cycle after acceptance, and keep it low until the buffer is transferred to the shift register.
REQ-013 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL, in IDLE with the buffer full, move to START on the next edge, load the shift register from the buffer, empty the buffer (tx_ready high the following cycle), and latch clks_per_bit for the whole frame.
REQ-015 SHALL ignore clks_per_bit changes made mid-frame; the latched value applies until STOP ends.
REQ-016 SHALL drive TX=0 in START, data bit[i] in DATA slot i (i=0..7), even parity (XOR of the 8 data bits) in PARITY, and TX=1 in STOP and IDLE.
REQ-017 SHALL hold each bit for exactly latched clks_per_bit+1 cycles, using a 10-bit counter from 0 to latched clks_per_bit and then reset to 0 at each bit boundary.
REQ-018 SHALL use a 3-bit bit index in DATA; leave DATA after index 7 completes, to PARITY if PARITY_EN=1 and to STOP otherwise.
REQ-019 SHALL set the frame length to (10+PARITY_EN)*(clks_per_bit+1) cycles, from the first TX=0 cycle to the last stop-bit cycle inclusive.
REQ-020 SHALL, at the end of STOP with the buffer full, go directly to START with no idle cycle between frames; otherwise go to IDLE.
REQ-021 SHALL drive TX from a register so that TX is glitch-free.
REQ-022 SHALL treat clks_per_bit=0 as legal, giving a 1-cycle bit period.
REQ-023 SHALL accept a new byte into the buffer during any state, including the same cycle the buffer is transferred to the shift register.
REQ-024 SHALL ensure transmitted parity makes the total count of ones across data and parity even.

Reset
REQ-025 SHALL, while rst is high, force TX=1, busy=0, tx_done=0, tx_ready=0, state IDLE, counter 0, bit index 0, and buffer empty.
REQ-026 SHALL raise tx_ready on the first cycle after rst deasserts.
REQ-027 SHALL, on rst asserted mid-frame, abort the frame with TX=1 on the next edge, discard the buffered byte, and not pulse tx_done.

Verification
REQ-028 SHALL cover: PARITY_EN=1, clks_per_bit=3, send 0xA5 -> TX sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles; tx_done after 44 cycles.
REQ-029 SHALL cover: send 0x07 -> parity bit=1; send 0x00 -> parity bit=0; a bench UART_RX loopback with the same clks_per_bit reports eoc_flag=1, parity_ok=1, and the correct buffer_RX.
REQ-030 SHALL cover: tx_valid held high with bytes 0x11, 0x22, 0x33 -> three frames back-to-back with no idle cycle, and tx_ready low whenever the buffer is occupied.
REQ-031 SHALL cover: PARITY_EN=0, clks_per_bit=0, send 0xFF -> 10-cycle frame 0,1,1,1,1,1,1,1,1,1.
REQ-032 SHALL cover: rst pulsed during DATA bit 4 -> TX=1 next cycle, busy=0, no tx_done, and the next byte is sent correctly.
REQ-033 SHALL cover: clks_per_bit changed from 5 to 9 mid-frame -> current frame keeps 6-cycle bits and the next frame uses 10-cycle bits.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, optional even parity, one-entry holding buffer.
// Each line bit lasts clks_per_bit+1 clocks; clks_per_bit is latched when a frame starts.
module uart_tx #(
  parameter int unsigned PARITY_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] clks_per_bit,
  input  logic [7:0] data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TX,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] cpb_q, cpb_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic       ready_q;
  logic       tx_q, tx_d;

  logic       bit_end;
  logic       accept;
  logic       load;

  assign bit_end = (cnt_q == cpb_q);
  assign accept  = tx_valid && ready_q;

  // Next-state and datapath; a frame is (re)loaded from the buffer in IDLE or at the end of STOP.
  always_comb begin
    state_d = state_q;
    cpb_d   = cpb_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (buf_full_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cnt_d = ((state_q == IDLE) || bit_end) ? 10'd0 : cnt_q + 10'd1;

    if (load) begin
      state_d = START;
      cpb_d   = clks_per_bit;
      shift_d = buf_q;
      par_d   = ^buf_q;
      idx_d   = 3'd0;
    end

    // Line level is derived from the next state so TX itself comes straight off a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (load) begin
      buf_full_d = 1'b0;
    end
    if (accept) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 10'd0;
      cpb_q      <= 10'd0;
      idx_q      <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      buf_q      <= 8'd0;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpb_q      <= cpb_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      ready_q    <= ~buf_full_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_ready = ready_q && !rst;
  assign TX       = tx_q;
  assign busy     = (state_q != IDLE) && !rst;
  assign tx_done  = (state_q == STOP) && bit_end && !rst;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of single frames on a parity and a no-parity instance,
// plus hand-written back-to-back, mid-frame bit-period change and mid-frame reset sequences.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [9:0] cpb_p, cpb_n;
  logic [7:0] data_p, data_n;
  logic       valid_p, valid_n;
  logic       ready_p, ready_n;
  logic       tx_p, tx_n;
  logic       busy_p, busy_n;
  logic       done_p, done_n;

  uart_tx #(.PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .clks_per_bit(cpb_p), .data_in(data_p), .tx_valid(valid_p),
    .tx_ready(ready_p), .TX(tx_p), .busy(busy_p), .tx_done(done_p)
  );

  uart_tx #(.PARITY_EN(0)) dut_n (
    .clk(clk), .rst(rst), .clks_per_bit(cpb_n), .data_in(data_n), .tx_valid(valid_n),
    .tx_ready(ready_n), .TX(tx_n), .busy(busy_n), .tx_done(done_n)
  );

  typedef struct {
    bit          np;     // 1 = no-parity instance
    logic [7:0]  data;
    logic [9:0]  cpb;
    logic [10:0] frame;  // line bit i at position i: start, d0..d7, [parity], stop
    int          len;    // first TX=0 cycle to tx_done cycle, inclusive
  } vec_t;

  vec_t vecs[9];
  int n_vec = 0;
  int n_err = 0;

  logic [10:0] word;
  int          len, ndone, waits;
  bit          stable;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic send(input bit np, input logic [7:0] d, input logic [9:0] cpb);
    int w;
    @(negedge clk);
    if (np) begin data_n = d; cpb_n = cpb; valid_n = 1'b1; end
    else    begin data_p = d; cpb_p = cpb; valid_p = 1'b1; end
    w = 0;
    while (!(np ? ready_n : ready_p) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid_p = 1'b0;
    valid_n = 1'b0;
    @(negedge clk);
    check($sformatf("ready_low_after_accept 0x%0h", d), np ? ready_n : ready_p, 0);
  endtask

  // Bench receiver: waits (bounded) for a start bit, samples every cycle of every bit slot.
  task automatic capture(input bit np, input int nbits, input int cpb,
                         output logic [10:0] w_o, output int len_o, output int nd_o,
                         output int waits_o, output bit stable_o);
    int c;
    logic lvl;
    w_o = '1; len_o = 0; nd_o = 0; stable_o = 1'b1; waits_o = 0; c = 0;
    while ((np ? tx_n : tx_p) !== 1'b0 && waits_o < 400) begin
      @(negedge clk);
      waits_o++;
    end
    if (waits_o >= 400) begin
      check("start_bit_timeout", 0, 1);
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k <= cpb; k++) begin
        c++;
        lvl = np ? tx_n : tx_p;
        if (k == 0) w_o[b] = lvl;
        else if (lvl !== w_o[b]) stable_o = 1'b0;
        if ((np ? done_n : done_p) === 1'b1) begin
          nd_o++;
          if (len_o == 0) len_o = c;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic check_frame(input string tag, input bit np, input logic [7:0] d,
                             input logic [10:0] exp_frame, input int exp_len);
    check({tag, " frame"}, np ? {1'b0, word[9:0]} : word, exp_frame);
    check({tag, " len"}, len, exp_len);
    check({tag, " done_pulses"}, ndone, 1);
    check({tag, " bits_stable"}, stable, 1);
    check({tag, " buffer_RX"}, word[8:1], d);
    check({tag, " eoc_flag"}, np ? word[9] : word[10], 1);
    if (!np) check({tag, " parity_ok"}, ^word[9:1], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 10'd3, 11'h54A, 44};
    vecs[1] = '{0, 8'h07, 10'd3, 11'h60E, 44};
    vecs[2] = '{0, 8'h00, 10'd3, 11'h400, 44};
    vecs[3] = '{0, 8'h80, 10'd1, 11'h700, 22};
    vecs[4] = '{0, 8'h5A, 10'd0, 11'h4B4, 11};
    vecs[5] = '{0, 8'hFF, 10'd2, 11'h5FE, 33};
    vecs[6] = '{1, 8'hFF, 10'd0, 11'h3FE, 10};
    vecs[7] = '{1, 8'h00, 10'd0, 11'h200, 10};
    vecs[8] = '{1, 8'h96, 10'd2, 11'h32C, 30};

    rst = 1'b1;
    cpb_p = 10'd3; cpb_n = 10'd0; data_p = 8'h00; data_n = 8'h00;
    valid_p = 1'b0; valid_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset TX", tx_p, 1);
    check("reset TX np", tx_n, 1);
    check("reset busy", busy_p, 0);
    check("reset tx_done", done_p, 0);
    check("reset tx_ready", ready_p, 0);
    rst = 1'b0;
    @(negedge clk);
    check("tx_ready after reset", ready_p, 1);
    check("tx_ready after reset np", ready_n, 1);

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].np, vecs[i].data, vecs[i].cpb);
      capture(vecs[i].np, vecs[i].np ? 10 : 11, int'(vecs[i].cpb), word, len, ndone, waits, stable);
      check_frame($sformatf("v%0d", i), vecs[i].np, vecs[i].data, vecs[i].frame, vecs[i].len);
    end

    // Back-to-back: tx_valid held high across 0x11, 0x22, 0x33.
    @(negedge clk);
    cpb_p = 10'd1;
    fork
      begin
        int k, g;
        logic [7:0] nxt;
        k = 0; g = 0;
        data_p = 8'h11; valid_p = 1'b1;
        while (k < 3 && g < 500) begin
          if (ready_p) begin
            @(posedge clk);
            #1;
            k++;
            nxt = (k == 1) ? 8'h22 : 8'h33;
            if (k < 3) data_p = nxt;
            else valid_p = 1'b0;
            @(negedge clk);
            check($sformatf("b2b ready_low_when_full %0d", k), ready_p, 0);
          end else begin
            @(negedge clk);
            g++;
          end
        end
        if (k < 3) check("b2b feeder_timeout", k, 3);
      end
      begin
        logic [10:0] exp_f;
        logic [7:0]  exp_d;
        for (int f = 0; f < 3; f++) begin
          capture(0, 11, 1, word, len, ndone, waits, stable);
          exp_f = (f == 0) ? 11'h422 : (f == 1) ? 11'h444 : 11'h466;
          exp_d = (f == 0) ? 8'h11 : (f == 1) ? 8'h22 : 8'h33;
          check_frame($sformatf("b2b%0d", f), 0, exp_d, exp_f, 22);
          if (f > 0) check($sformatf("b2b%0d idle_cycles", f), waits, 0);
        end
      end
    join

    // clks_per_bit changed 5 -> 9 during the first frame; second byte queued meanwhile.
    @(negedge clk);
    data_p = 8'h55; cpb_p = 10'd5; valid_p = 1'b1;
    @(posedge clk);
    #1;
    valid_p = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cpb start_bit", tx_p, 0);
    cpb_p = 10'd9; data_p = 8'hC3; valid_p = 1'b1;
    fork
      begin @(posedge clk); #1; valid_p = 1'b0; end
      capture(0, 11, 5, word, len, ndone, waits, stable);
    join
    check_frame("cpb5", 0, 8'h55, 11'h4AA, 66);
    capture(0, 11, 9, word, len, ndone, waits, stable);
    check_frame("cpb9", 0, 8'hC3, 11'h586, 110);
    check("cpb9 idle_cycles", waits, 0);

    // Reset during DATA bit 4 with a second byte sitting in the buffer.
    send(0, 8'hA5, 10'd3);
    begin
      int w, bad;
      w = 0;
      while (tx_p !== 1'b0 && w < 400) begin @(negedge clk); w++; end
      check("rst_mid start_found", w < 400, 1);
      @(negedge clk);
      data_p = 8'h99; valid_p = 1'b1;
      @(posedge clk);
      #1;
      valid_p = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_mid data_bit4", tx_p, 0);
      check("rst_mid busy_before", busy_p, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid TX", tx_p, 1);
      check("rst_mid busy", busy_p, 0);
      check("rst_mid tx_done", done_p, 0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (40) begin
        @(negedge clk);
        if (tx_p !== 1'b1 || busy_p !== 1'b0 || done_p !== 1'b0) bad++;
      end
      check("rst_mid buffer_discarded", bad, 0);
    end
    send(0, 8'h3C, 10'd3);
    capture(0, 11, 3, word, len, ndone, waits, stable);
    check_frame("after_rst", 0, 8'h3C, 11'h478, 44);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
